// File: rtl/jtag_ahb_master_if.sv
// Bundles the TAP-side request/acknowledge signals and the AHB-Lite master bus.
// The master modport is the bridge's view; the slave modport is the TAP and AHB side.
interface jtag_ahb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  REQ_TOGGLE;
  logic                  REQ_WRITE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  ACK_TOGGLE;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  BUSY;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  REQ_TOGGLE, REQ_WRITE, REQ_ADDR, REQ_WDATA, HRDATA, HREADY, HRESP,
    output ACK_TOGGLE, RSP_RDATA, RSP_ERR, BUSY,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output REQ_TOGGLE, REQ_WRITE, REQ_ADDR, REQ_WDATA, HRDATA, HREADY, HRESP,
    input  ACK_TOGGLE, RSP_RDATA, RSP_ERR, BUSY,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/jtag_ahb_master.sv
// Single-transfer AHB-Lite master driven by toggle requests from the JTAG TAP domain.
// Each request becomes one NONSEQ beat; the result is returned through a toggle acknowledge.
module jtag_ahb_master #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  jtag_ahb_master_if.master bus
);

  localparam int         CNT_W         = $clog2(SYNC_STAGES + 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  w_req_s;
  logic                  w_pending;
  logic [CNT_W-1:0]      r_init_cnt, w_init_cnt_nxt;
  logic                  r_req_seen, w_req_seen_nxt;
  logic                  r_write, w_write_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_err, w_err_nxt;
  logic [ADDR_WIDTH-1:0] r_haddr, w_haddr_nxt;
  logic [1:0]            r_htrans, w_htrans_nxt;
  logic                  r_hwrite, w_hwrite_nxt;
  logic [DATA_WIDTH-1:0] r_hwdata, w_hwdata_nxt;
  logic                  r_ack, w_ack_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_busy, w_busy_nxt;

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  assign w_pending = (w_req_s != r_req_seen);

  // Toggle synchronizer from the TCK domain
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.REQ_TOGGLE};
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, captured request and bus/response outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_req_seen_nxt  = r_req_seen;
    w_write_nxt     = r_write;
    w_wdata_nxt     = r_wdata;
    w_err_nxt       = r_err;
    w_haddr_nxt     = r_haddr;
    w_htrans_nxt    = r_htrans;
    w_hwrite_nxt    = r_hwrite;
    w_hwdata_nxt    = r_hwdata;
    w_ack_nxt       = r_ack;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_busy_nxt      = r_busy;

    case (r_state)
      ST_INIT: begin
        // Adopt the value req_s takes on this edge, so a level present at release is not a request
        if (r_init_cnt == CNT_W'(SYNC_STAGES - 1)) begin
          w_req_seen_nxt = r_sync[SYNC_STAGES-2];
          w_state_nxt    = ST_IDLE;
        end else begin
          w_init_cnt_nxt = r_init_cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_pending) begin
          w_write_nxt  = bus.REQ_WRITE;
          w_wdata_nxt  = bus.REQ_WDATA;
          w_haddr_nxt  = bus.REQ_ADDR;
          w_hwrite_nxt = bus.REQ_WRITE;
          w_htrans_nxt = HTRANS_NONSEQ;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_ADDR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          w_htrans_nxt = HTRANS_IDLE;
          w_err_nxt    = 1'b0;
          w_state_nxt  = ST_DATA;
          if (r_write) begin
            w_hwdata_nxt = r_wdata;
          end else begin
            w_hwdata_nxt = r_hwdata;
          end
        end else begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (bus.HREADY) begin
          w_rsp_err_nxt = bus.HRESP | r_err;
          w_state_nxt   = ST_RESP;
          // Read data from an errored transfer is not meaningful, so the last good value is kept
          if (!r_write && !(bus.HRESP | r_err)) begin
            w_rsp_rdata_nxt = bus.HRDATA;
          end else begin
            w_rsp_rdata_nxt = r_rsp_rdata;
          end
        end else if (bus.HRESP) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
      end
      ST_RESP: begin
        w_ack_nxt      = ~r_ack;
        w_busy_nxt     = 1'b0;
        w_req_seen_nxt = ~r_req_seen;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_htrans_nxt = HTRANS_IDLE;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = ST_INIT;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_init_cnt  <= '0;
      r_req_seen  <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_haddr     <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_ack       <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_init_cnt  <= w_init_cnt_nxt;
      r_req_seen  <= w_req_seen_nxt;
      r_write     <= w_write_nxt;
      r_wdata     <= w_wdata_nxt;
      r_err       <= w_err_nxt;
      r_haddr     <= w_haddr_nxt;
      r_htrans    <= w_htrans_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_hwdata    <= w_hwdata_nxt;
      r_ack       <= w_ack_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.HADDR      = r_haddr;
  assign bus.HTRANS     = r_htrans;
  assign bus.HWRITE     = r_hwrite;
  assign bus.HSIZE      = 3'b010;
  assign bus.HBURST     = 3'b000;
  assign bus.HWDATA     = r_hwdata;
  assign bus.ACK_TOGGLE = r_ack;
  assign bus.RSP_RDATA  = r_rsp_rdata;
  assign bus.RSP_ERR    = r_rsp_err;
  assign bus.BUSY       = r_busy;

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Randomized self-checking bench for jtag_ahb_master: drives toggle requests and plays the AHB slave,
// predicting every response from a transaction-level model of the request/acknowledge contract.
module tb_jtag_ahb_master;
  localparam int SS = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  jtag_ahb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  jtag_ahb_master #(.SYNC_STAGES(SS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus.master)
  );

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model of what the TAP side should observe
  logic          exp_ack;
  logic          exp_err;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] exp_hwdata;

  // Current and queued request
  logic          cur_w, nxt_w;
  logic [AW-1:0] cur_a, nxt_a;
  logic [DW-1:0] cur_d, nxt_d;
  int unsigned   t_launch;
  int            n_ns;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic model_reset();
    exp_ack    = 1'b0;
    exp_err    = 1'b0;
    exp_rdata  = '0;
    exp_hwdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_htrans"}, 64'(bus.HTRANS), 64'(2'b00));
    check_val({tag, "_haddr"},  64'(bus.HADDR), 64'(0));
    check_val({tag, "_hwrite"}, 64'(bus.HWRITE), 64'(0));
    check_val({tag, "_hwdata"}, 64'(bus.HWDATA), 64'(0));
    check_val({tag, "_ack"},    64'(bus.ACK_TOGGLE), 64'(0));
    check_val({tag, "_rdata"},  64'(bus.RSP_RDATA), 64'(0));
    check_val({tag, "_err"},    64'(bus.RSP_ERR), 64'(0));
    check_val({tag, "_busy"},   64'(bus.BUSY), 64'(0));
    check_val({tag, "_hsize"},  64'(bus.HSIZE), 64'(3'b010));
    check_val({tag, "_hburst"}, 64'(bus.HBURST), 64'(3'b000));
  endtask

  task automatic launch(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.REQ_WRITE  = w;
    bus.REQ_ADDR   = a;
    bus.REQ_WDATA  = d;
    cur_w = w;
    cur_a = a;
    cur_d = d;
    bus.REQ_TOGGLE = ~bus.REQ_TOGGLE;
    t_launch = cyc;
  endtask

  // emode: 0 no error, 1 two-cycle ERROR ending the data phase, 2 ERROR only on the first wait cycle
  task automatic run_xfer(input int aw, input int dw, input int emode, input logic [DW-1:0] rd,
                          input bit chain);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            n;
    w = cur_w;
    a = cur_a;
    d = cur_d;
    n = 0;
    while (bus.HTRANS != 2'b10 && n < 40) begin
      step();
      n++;
    end
    check_val("nonseq_seen", 64'(bus.HTRANS), 64'(2'b10));
    if (bus.HTRANS != 2'b10) return;
    check_val("req_latency", 64'(cyc - t_launch), 64'(SS + 1));
    check_val("haddr", 64'(bus.HADDR), 64'(a));
    check_val("hwrite", 64'(bus.HWRITE), 64'(w));
    check_val("busy_set", 64'(bus.BUSY), 64'(1));
    for (int i = 0; i < aw; i++) begin
      bus.HREADY = 1'b0;
      step();
      check_val("htrans_addr_hold", 64'(bus.HTRANS), 64'(2'b10));
      check_val("haddr_hold", 64'(bus.HADDR), 64'(a));
    end
    bus.HREADY = 1'b1;
    step();
    if (w) exp_hwdata = d;
    check_val("htrans_data_idle", 64'(bus.HTRANS), 64'(2'b00));
    check_val("hwdata", 64'(bus.HWDATA), 64'(exp_hwdata));
    for (int i = 0; i < dw; i++) begin
      bus.HREADY = 1'b0;
      bus.HRESP  = ((emode == 1) && (i == dw - 1)) || ((emode == 2) && (i == 0));
      bus.HRDATA = $urandom;
      step();
      check_val("htrans_wait_idle", 64'(bus.HTRANS), 64'(2'b00));
      check_val("hwdata_hold", 64'(bus.HWDATA), 64'(exp_hwdata));
      check_val("busy_wait", 64'(bus.BUSY), 64'(1));
    end
    bus.HREADY = 1'b1;
    bus.HRESP  = (emode == 1);
    bus.HRDATA = rd;
    step();
    bus.HRESP  = 1'b0;
    bus.HRDATA = $urandom;
    check_val("ack_not_yet", 64'(bus.ACK_TOGGLE), 64'(exp_ack));
    if (chain) launch(nxt_w, nxt_a, nxt_d);
    step();
    exp_ack = ~exp_ack;
    exp_err = (emode != 0);
    if (!w && emode == 0) exp_rdata = rd;
    check_val("ack", 64'(bus.ACK_TOGGLE), 64'(exp_ack));
    check_val("rsp_err", 64'(bus.RSP_ERR), 64'(exp_err));
    check_val("rsp_rdata", 64'(bus.RSP_RDATA), 64'(exp_rdata));
    check_val("busy_clear", 64'(bus.BUSY), 64'(0));
  endtask

  task automatic count_nonseq(input int cycles);
    n_ns = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.HTRANS == 2'b10) n_ns++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  aw, dw, em;
    bit  pend, ch;
    int  n;
    bus.REQ_TOGGLE = 1'b0;
    bus.REQ_WRITE  = 1'b0;
    bus.REQ_ADDR   = '0;
    bus.REQ_WDATA  = '0;
    bus.HRDATA     = '0;
    bus.HREADY     = 1'b1;
    bus.HRESP      = 1'b0;
    model_reset();

    repeat (5) @(negedge HCLK);
    check_reset_outputs("por");
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("init_htrans", 64'(bus.HTRANS), 64'(2'b00));
    end

    // Directed transfers
    launch(1'b1, 32'h2000_0010, 32'hDEAD_BEEF);
    run_xfer(0, 0, 0, 32'h0, 1'b0);
    launch(1'b0, 32'h4000_0004, 32'h0);
    run_xfer(0, 2, 0, 32'h1234_5678, 1'b0);
    launch(1'b0, 32'h4000_0008, 32'h0);
    run_xfer(1, 1, 1, 32'hBAD0_BAD0, 1'b0);
    launch(1'b0, 32'h4000_000C, 32'h0);
    run_xfer(0, 2, 2, 32'h5555_AAAA, 1'b0);
    nxt_w = 1'b0;
    nxt_a = 32'h4000_0010;
    nxt_d = 32'h0;
    launch(1'b1, 32'h2000_0020, 32'hCAFE_F00D);
    run_xfer(1, 1, 0, 32'h0, 1'b1);
    run_xfer(0, 0, 0, 32'h0BAD_F00D, 1'b0);

    // Randomized transfers, some issued back-to-back from the response cycle
    pend = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!pend) launch(1'($urandom_range(0, 1)), $urandom, $urandom);
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      em = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if (em != 0 && dw == 0) dw = 1;
      ch = ($urandom_range(0, 3) == 0) && (i < 29);
      if (ch) begin
        nxt_w = 1'($urandom_range(0, 1));
        nxt_a = $urandom;
        nxt_d = $urandom;
      end
      run_xfer(aw, dw, em, $urandom, ch);
      pend = ch;
    end

    // Toggle level present across reset release is not a request
    HRESETn = 1'b0;
    bus.REQ_TOGGLE = 1'b1;
    model_reset();
    repeat (3) step();
    check_reset_outputs("rst_hi");
    HRESETn = 1'b1;
    count_nonseq(12);
    check_val("no_req_at_release", 64'(n_ns), 64'(0));
    launch(1'b1, 32'h2000_0100, 32'h0123_4567);
    run_xfer(0, 1, 0, 32'h0, 1'b0);
    count_nonseq(8);
    check_val("single_transfer", 64'(n_ns), 64'(0));

    // Reset during data-phase wait states
    launch(1'b0, 32'h4000_0040, 32'h0);
    n = 0;
    while (bus.HTRANS != 2'b10 && n < 40) begin
      step();
      n++;
    end
    check_val("mid_nonseq", 64'(bus.HTRANS), 64'(2'b10));
    bus.HREADY = 1'b1;
    step();
    bus.HREADY = 1'b0;
    step();
    check_val("mid_busy_before", 64'(bus.BUSY), 64'(1));
    check_val("mid_ack_before", 64'(bus.ACK_TOGGLE), 64'(exp_ack));
    HRESETn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("mid_rst");
    bus.HREADY = 1'b1;
    repeat (3) step();
    HRESETn = 1'b1;
    count_nonseq(12);
    check_val("no_req_after_mid_rst", 64'(n_ns), 64'(0));
    launch(1'b0, 32'h4000_0044, 32'h0);
    run_xfer(1, 1, 0, 32'h7777_8888, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
